// File: rtl/pe_array_sequencer_pkg.sv
// pe_array_sequencer_pkg
//    Shared definitions for the PE array sequencer: default array/score/length
//    widths, the sequencer state encoding and the segment enable-mask helper.
package pe_array_sequencer_pkg;

   localparam int PE_NUM     = 64;    // PE cells in the array (power of two, >= 2)
   localparam int VEF_BIT    = 12;    // V/E/F score width, unsigned
   localparam int LEN_BIT    = 16;    // width of the s and t length fields
   localparam int MAX_PE_NUM = 1024;  // widest array the mask helper can describe

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD_S,
      ST_WAIT_S,
      ST_RUN,
      ST_DRAIN,
      ST_NEXT,
      ST_DONE
   } state_t;

   // Thermometer mask with the low seg_len bits set; callers keep the low
   // PE_NUM bits. Shifting all-ones left by seg_len leaves zeros in the bits
   // that must be enabled, so the inversion yields the mask.
   function automatic logic [MAX_PE_NUM-1:0] seg_mask(input int unsigned seg_len);
      return ~({MAX_PE_NUM{1'b1}} << seg_len);
   endfunction

endpackage

// File: rtl/pe_score_max.sv
// pe_score_max
//    Registered running maximum of an unsigned score stream.
//    clk, rst_n    : clock, asynchronous active-low reset
//    clr           : synchronous clear to zero (wins over en)
//    en            : score is a candidate this cycle
//    score         : candidate score
//    max_score     : largest candidate seen since the last clear
module pe_score_max
   import pe_array_sequencer_pkg::*;
#(
   parameter int WIDTH = VEF_BIT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] score,
   output logic [WIDTH-1:0] max_score
);

   logic [WIDTH-1:0] max_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         max_reg <= '0;
      end else if (clr) begin
         max_reg <= '0;
      end else if (en && (score > max_reg)) begin
         max_reg <= score;
      end
   end

   assign max_score = max_reg;

endmodule

// File: rtl/pe_array_sequencer.sv
// pe_array_sequencer
//    Walks the systolic PE array through a full Smith-Waterman alignment:
//    the query is loaded PE_NUM symbols at a time, the whole target is
//    streamed through for each segment, the wavefront is drained, and the
//    largest cell score seen across all passes is reported at the end.
//    i_start / i_s_len / i_t_len : job request, lengths latched on start
//    o_busy / o_valid / o_result : job in progress, result pulse and value
//    o_update_s / i_s_valid      : next query segment request / present
//    o_t_ready / i_t_valid       : target symbol handshake
//    o_pe_enable / o_pe_lock / o_newline : PE chain controls
//    i_score / i_score_valid     : cell scores leaving the array
module pe_array_sequencer #(
   parameter int PE_NUM  = pe_array_sequencer_pkg::PE_NUM,
   parameter int VEF_BIT = pe_array_sequencer_pkg::VEF_BIT,
   parameter int LEN_BIT = pe_array_sequencer_pkg::LEN_BIT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_start,
   input  logic [LEN_BIT-1:0] i_s_len,
   input  logic [LEN_BIT-1:0] i_t_len,
   output logic               o_busy,
   output logic               o_valid,
   output logic [VEF_BIT-1:0] o_result,
   output logic               o_update_s,
   input  logic               i_s_valid,
   output logic               o_t_ready,
   input  logic               i_t_valid,
   output logic [PE_NUM-1:0]  o_pe_enable,
   output logic               o_pe_lock,
   output logic               o_newline,
   input  logic [VEF_BIT-1:0] i_score,
   input  logic               i_score_valid
);

   import pe_array_sequencer_pkg::*;

   state_t             state_reg, state_next;
   logic [LEN_BIT-1:0] s_rem_reg, s_rem_next;       // query symbols not yet covered by a pass
   logic [LEN_BIT-1:0] t_len_reg, t_len_next;
   logic [LEN_BIT-1:0] t_cnt_reg, t_cnt_next;
   logic [LEN_BIT-1:0] seg_len_reg, seg_len_next;
   logic [LEN_BIT-1:0] drain_cnt_reg, drain_cnt_next;
   logic [PE_NUM-1:0]  enable_reg, enable_next;
   logic               valid_reg, valid_next;
   logic [VEF_BIT-1:0] result_reg, result_next;

   logic               max_clr;
   logic               max_en;
   logic [VEF_BIT-1:0] max_score;
   logic [LEN_BIT-1:0] seg_len_calc;
   logic               transfer;
   logic               last_transfer;

   // Remaining query length doubles as pass*PE_NUM bookkeeping: the current
   // segment is a full array unless fewer symbols remain.
   assign seg_len_calc  = (s_rem_reg >= LEN_BIT'(PE_NUM)) ? LEN_BIT'(PE_NUM) : s_rem_reg;
   assign transfer      = (state_reg == ST_RUN) && i_t_valid;
   assign last_transfer = transfer && (t_cnt_reg == (t_len_reg - LEN_BIT'(1)));
   assign max_en        = ((state_reg == ST_RUN) || (state_reg == ST_DRAIN)) && i_score_valid;

   pe_score_max #(
      .WIDTH (VEF_BIT)
   ) u_score_max (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (max_clr),
      .en        (max_en),
      .score     (i_score),
      .max_score (max_score)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         s_rem_reg     <= '0;
         t_len_reg     <= '0;
         t_cnt_reg     <= '0;
         seg_len_reg   <= '0;
         drain_cnt_reg <= '0;
         enable_reg    <= '0;
         valid_reg     <= 1'b0;
         result_reg    <= '0;
      end else begin
         state_reg     <= state_next;
         s_rem_reg     <= s_rem_next;
         t_len_reg     <= t_len_next;
         t_cnt_reg     <= t_cnt_next;
         seg_len_reg   <= seg_len_next;
         drain_cnt_reg <= drain_cnt_next;
         enable_reg    <= enable_next;
         valid_reg     <= valid_next;
         result_reg    <= result_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      s_rem_next     = s_rem_reg;
      t_len_next     = t_len_reg;
      t_cnt_next     = t_cnt_reg;
      seg_len_next   = seg_len_reg;
      drain_cnt_next = drain_cnt_reg;
      enable_next    = enable_reg;
      valid_next     = 1'b0;
      result_next    = '0;
      max_clr        = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (i_start) begin
               s_rem_next = i_s_len;
               t_len_next = i_t_len;
               max_clr    = 1'b1;
               state_next = ((i_s_len == '0) || (i_t_len == '0)) ? ST_DONE : ST_LOAD_S;
            end
         end
         ST_LOAD_S: begin
            state_next = ST_WAIT_S;
         end
         ST_WAIT_S: begin
            if (i_s_valid) begin
               seg_len_next = seg_len_calc;
               enable_next  = PE_NUM'(seg_mask(32'(seg_len_calc)));
               t_cnt_next   = '0;
               state_next   = ST_RUN;
            end
         end
         ST_RUN: begin
            if (transfer) begin
               t_cnt_next = t_cnt_reg + LEN_BIT'(1);
            end
            if (last_transfer) begin
               // A single-cell segment has no wavefront left to flush.
               if (seg_len_reg > LEN_BIT'(1)) begin
                  drain_cnt_next = seg_len_reg - LEN_BIT'(1);
                  state_next     = ST_DRAIN;
               end else begin
                  state_next     = ST_NEXT;
               end
            end
         end
         ST_DRAIN: begin
            if (drain_cnt_reg == LEN_BIT'(1)) begin
               state_next = ST_NEXT;
            end else begin
               drain_cnt_next = drain_cnt_reg - LEN_BIT'(1);
            end
         end
         ST_NEXT: begin
            s_rem_next = s_rem_reg - seg_len_reg;
            state_next = (s_rem_reg == seg_len_reg) ? ST_DONE : ST_LOAD_S;
         end
         ST_DONE: begin
            // Result is registered so the pulse lands as busy drops.
            valid_next  = 1'b1;
            result_next = max_score;
            enable_next = '0;
            state_next  = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign o_busy      = (state_reg != ST_IDLE);
   assign o_valid     = valid_reg;
   assign o_result    = result_reg;
   assign o_update_s  = (state_reg == ST_LOAD_S);
   assign o_t_ready   = (state_reg == ST_RUN);
   assign o_pe_lock   = (state_reg == ST_RUN) && !i_t_valid;
   assign o_newline   = transfer && (t_cnt_reg == '0);
   assign o_pe_enable = enable_reg;

endmodule

// File: tb/tb_pe_array_sequencer.sv
module tb_pe_array_sequencer;

   localparam int PE = 8;
   localparam int VB = 12;
   localparam int LB = 16;

   localparam int PH_LOAD  = 1;
   localparam int PH_WAIT  = 2;
   localparam int PH_RUN   = 3;
   localparam int PH_DRAIN = 4;
   localparam int PH_NEXT  = 5;
   localparam int PH_DONE  = 6;
   localparam int PH_VALID = 7;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_start = 1'b0;
   logic [LB-1:0] i_s_len = '0;
   logic [LB-1:0] i_t_len = '0;
   logic          o_busy;
   logic          o_valid;
   logic [VB-1:0] o_result;
   logic          o_update_s;
   logic          i_s_valid = 1'b0;
   logic          o_t_ready;
   logic          i_t_valid = 1'b0;
   logic [PE-1:0] o_pe_enable;
   logic          o_pe_lock;
   logic          o_newline;
   logic [VB-1:0] i_score = '0;
   logic          i_score_valid = 1'b0;

   int errors = 0;
   int checks = 0;

   logic [VB-1:0] sb_q[$];

   typedef struct {
      int            ph;
      bit            tv;
      bit            sv;
      bit            scv;
      logic [VB-1:0] sc;
      logic [PE-1:0] mask;
      bit            nl;
   } cyc_t;

   cyc_t sched[$];

   pe_array_sequencer #(
      .PE_NUM  (PE),
      .VEF_BIT (VB),
      .LEN_BIT (LB)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_start       (i_start),
      .i_s_len       (i_s_len),
      .i_t_len       (i_t_len),
      .o_busy        (o_busy),
      .o_valid       (o_valid),
      .o_result      (o_result),
      .o_update_s    (o_update_s),
      .i_s_valid     (i_s_valid),
      .o_t_ready     (o_t_ready),
      .i_t_valid     (i_t_valid),
      .o_pe_enable   (o_pe_enable),
      .o_pe_lock     (o_pe_lock),
      .o_newline     (o_newline),
      .i_score       (i_score),
      .i_score_valid (i_score_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard side: every result pulse must match the oldest outstanding job.
   always @(negedge clk) begin
      if (rst_n && o_valid) begin
         if (sb_q.size() == 0) begin
            check("unexpected_valid", 32'(o_valid), 32'd0);
         end else begin
            logic [VB-1:0] exp_res;
            exp_res = sb_q.pop_front();
            $display("txn result=%0d expected=%0d", o_result, exp_res);
            check("result", 32'(o_result), 32'(exp_res));
         end
      end
   end

   task automatic push_cyc(input int ph, input bit tv, input bit sv, input bit scv,
                           input logic [VB-1:0] sc, input logic [PE-1:0] mask, input bit nl);
      cyc_t c;
      c.ph = ph; c.tv = tv; c.sv = sv; c.scv = scv; c.sc = sc; c.mask = mask; c.nl = nl;
      sched.push_back(c);
   endtask

   // mode 0: random scores; mode 1: scores 3,7,5 on the first three RUN cycles only
   task automatic gen_score(input int mode, input int idx, output bit scv, output logic [VB-1:0] sc);
      if (mode == 1) begin
         scv = (idx < 3);
         sc  = (idx == 0) ? VB'(3) : (idx == 1) ? VB'(7) : (idx == 2) ? VB'(5) : VB'(0);
      end else begin
         scv = 1'($urandom_range(0, 1));
         sc  = VB'($urandom_range(0, 2000));
      end
   endtask

   task automatic outputs_zero(input string tag);
      check({tag, "_busy"},   32'(o_busy), 0);
      check({tag, "_valid"},  32'(o_valid), 0);
      check({tag, "_result"}, 32'(o_result), 0);
      check({tag, "_upd"},    32'(o_update_s), 0);
      check({tag, "_ready"},  32'(o_t_ready), 0);
      check({tag, "_enable"}, 32'(o_pe_enable), 0);
      check({tag, "_lock"},   32'(o_pe_lock), 0);
      check({tag, "_newline"},32'(o_newline), 0);
   endtask

   // Called at a cycle start (just after a rising edge) with the DUT idle.
   task automatic run_job(input int s_len, input int t_len, input logic [31:0] pat,
                          input int wait_cyc, input int mode, input bit poke, input bit abort);
      int            rem, seg, k, xfer, nrun;
      logic [VB-1:0] mx, sc;
      logic [PE-1:0] cur_mask, new_mask;
      bit            b, scv;
      cyc_t          c;

      sched.delete();
      rem = s_len; k = 0; mx = '0; cur_mask = '0; nrun = 0;
      if (s_len != 0 && t_len != 0) begin
         while (rem > 0) begin
            seg = (rem > PE) ? PE : rem;
            new_mask = '0;
            for (int j = 0; j < seg; j++) new_mask[j] = 1'b1;
            // decoy scores of all-ones outside RUN/DRAIN must never reach the max
            push_cyc(PH_LOAD, 0, 1, 1, '1, cur_mask, 0);
            for (int j = 0; j < wait_cyc; j++) push_cyc(PH_WAIT, 0, 0, 1, '1, cur_mask, 0);
            push_cyc(PH_WAIT, 0, 1, 1, '1, cur_mask, 0);
            cur_mask = new_mask;
            xfer = 0;
            while (xfer < t_len) begin
               b = pat[k % 32];
               k++;
               gen_score(mode, nrun, scv, sc);
               nrun++;
               if (scv && sc > mx) mx = sc;
               push_cyc(PH_RUN, b, 0, scv, sc, cur_mask, b && (xfer == 0));
               if (b) xfer++;
            end
            for (int j = 1; j < seg; j++) begin
               gen_score(mode, 1000, scv, sc);
               if (scv && sc > mx) mx = sc;
               push_cyc(PH_DRAIN, 1'($urandom_range(0, 1)), 0, scv, sc, cur_mask, 0);
            end
            push_cyc(PH_NEXT, 0, 0, 1, '1, cur_mask, 0);
            rem -= seg;
         end
      end
      push_cyc(PH_DONE, 0, 0, 1, '1, cur_mask, 0);
      push_cyc(PH_VALID, 0, 0, 0, '0, '0, 0);

      i_start = 1'b1;
      i_s_len = LB'(s_len);
      i_t_len = LB'(t_len);
      sb_q.push_back(mx);
      @(posedge clk);
      #1;
      i_start = 1'b0;

      foreach (sched[i]) begin
         c = sched[i];
         i_t_valid     = c.tv;
         i_s_valid     = c.sv;
         i_score_valid = c.scv;
         i_score       = c.sc;
         if (poke && c.ph == PH_RUN) begin
            i_start = 1'b1; i_s_len = '0; i_t_len = LB'(1);
         end else begin
            i_start = 1'b0; i_s_len = LB'(s_len); i_t_len = LB'(t_len);
         end
         if (abort && c.ph == PH_DRAIN) begin
            #2;
            rst_n = 1'b0;
            #1;
            outputs_zero("abort");
            sb_q.delete();
            @(negedge clk);
            check("abort_hold_valid", 32'(o_valid), 0);
            rst_n = 1'b1;
            @(posedge clk);
            #1;
            check("abort_after_busy", 32'(o_busy), 0);
            i_t_valid = 1'b0; i_s_valid = 1'b0; i_score_valid = 1'b0; i_start = 1'b0;
            $display("txn aborted by reset s_len=%0d t_len=%0d", s_len, t_len);
            return;
         end
         @(negedge clk);
         check("busy",     32'(o_busy),      32'(c.ph != PH_VALID));
         check("update_s", 32'(o_update_s),  32'(c.ph == PH_LOAD));
         check("t_ready",  32'(o_t_ready),   32'(c.ph == PH_RUN));
         check("lock",     32'(o_pe_lock),   32'(c.ph == PH_RUN && !c.tv));
         check("newline",  32'(o_newline),   32'(c.nl));
         check("enable",   32'(o_pe_enable), 32'(c.mask));
         check("valid",    32'(o_valid),     32'(c.ph == PH_VALID));
         @(posedge clk);
         #1;
      end
      i_t_valid = 1'b0; i_s_valid = 1'b0; i_score_valid = 1'b0; i_score = '0; i_start = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      #3;
      outputs_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_job(4,  4, 32'hFFFF_FFFF, 0, 1, 0, 0);   // single pass, scores 3,7,5
      run_job(20, 6, 32'hFFFF_FFFF, 1, 0, 0, 0);   // three passes, masks FF,FF,0F
      run_job(8,  4, 32'h9999_9999, 0, 0, 0, 0);   // t_valid 1,0,0,1 stalls
      run_job(0,  5, 32'hFFFF_FFFF, 0, 0, 0, 0);   // empty query
      run_job(3,  0, 32'hFFFF_FFFF, 0, 0, 0, 0);   // empty target
      run_job(5,  3, 32'hFFFF_FFFF, 0, 0, 1, 0);   // start poked during RUN
      run_job(5,  4, 32'hFFFF_FFFF, 0, 0, 0, 1);   // reset in DRAIN
      run_job(3,  2, 32'hFFFF_FFFF, 2, 0, 0, 0);   // fresh job after reset
      run_job(9,  3, 32'hB6D5_3A71, 0, 0, 0, 0);   // one-cell last segment
      run_job(16, 1, 32'hFFFF_FFFF, 0, 0, 0, 0);   // exact multiple of the array

      repeat (3) @(posedge clk);
      check("sb_empty", 32'(sb_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
